// File: rtl/wfg_record_pat_if.sv
// wfg_record_pat_if -- AXI-Stream style output channel of the pattern recorder.
//   tvalid : word available (driven by recorder)
//   tdata  : captured sample, zero-extended (driven by recorder)
//   tlast  : last word of a packet (driven by recorder)
//   tready : downstream ready (driven by consumer)
interface wfg_record_pat_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/wfg_record_pat.sv
// wfg_record_pat -- samples asynchronous input pins on selected sync pulses,
// decimates the pulse stream, packetises the captured words and buffers them
// in a small FIFO feeding an AXI-Stream output.
//
// Ports:
//   clk, rst_n            : block clock, asynchronous active-low reset
//   wfg_core_sync_i       : core sync pulse (one clk wide)
//   wfg_subcore_sync_i    : subcore sync pulse (one clk wide)
//   ctrl_en_q_i           : recorder enable; 0 holds counters at zero
//   cfg_core_sel_q_i      : 0 = core pulse, 1 = subcore pulse
//   cfg_decim_q_i         : capture every (n+1)th selected pulse
//   cfg_pktlen_q_i        : words per packet minus one
//   cfg_chmask_q_i        : per-channel mask, 0 forces the bit low
//   pat_din_i             : asynchronous input pins
//   wfg_axis              : output stream (master modport)
//   overflow_o            : sticky flag, a captured word was dropped
//   overflow_clr_i        : clears overflow_o (set wins)
module wfg_record_pat #(
    parameter int CHANNELS        = 32,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wfg_core_sync_i,
    input  logic                wfg_subcore_sync_i,
    input  logic                ctrl_en_q_i,
    input  logic                cfg_core_sel_q_i,
    input  logic [7:0]          cfg_decim_q_i,
    input  logic [7:0]          cfg_pktlen_q_i,
    input  logic [CHANNELS-1:0] cfg_chmask_q_i,
    input  logic [CHANNELS-1:0] pat_din_i,
    wfg_record_pat_if.master    wfg_axis,
    output logic                overflow_o,
    input  logic                overflow_clr_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CHANNELS-1:0]      sync1;
    logic [CHANNELS-1:0]      sync2;
    logic [7:0]               dcnt;
    logic [7:0]               pcnt;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;
    logic [AXIS_DATA_WIDTH:0] mem [FIFO_DEPTH];

    logic                       sel_sync;
    logic                       hit;
    logic                       full;
    logic                       pop;
    logic                       push;
    logic                       drop;
    logic                       cap_last;
    logic [AXIS_DATA_WIDTH-1:0] cap_data;

    assign sel_sync = cfg_core_sel_q_i ? wfg_subcore_sync_i : wfg_core_sync_i;
    assign hit      = ctrl_en_q_i && sel_sync && (dcnt == cfg_decim_q_i);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign pop      = (count != '0) && wfg_axis.tready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push     = hit && (!full || pop);
    assign drop     = hit && full && !pop;
    assign cap_last = (pcnt == cfg_pktlen_q_i);

    always_comb begin
        cap_data                 = '0;
        cap_data[CHANNELS-1:0]   = sync2 & cfg_chmask_q_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pat_din_i;
            sync2 <= sync1;
        end
    end

    // dcnt advances on every selected pulse (dropped words included);
    // pcnt only on words that actually enter the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt <= '0;
            pcnt <= '0;
        end else if (!ctrl_en_q_i) begin
            dcnt <= '0;
            pcnt <= '0;
        end else begin
            if (sel_sync) begin
                dcnt <= (dcnt == cfg_decim_q_i) ? 8'd0 : dcnt + 8'd1;
            end
            if (push) begin
                pcnt <= cap_last ? 8'd0 : pcnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cap_last, cap_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_o <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
        end else if (overflow_clr_i) begin
            overflow_o <= 1'b0;
        end
    end

    // Head entry is masked while empty so stale memory never shows on the bus.
    always_comb begin
        wfg_axis.tvalid = (count != '0);
        wfg_axis.tdata  = '0;
        wfg_axis.tlast  = 1'b0;
        if (count != '0) begin
            wfg_axis.tdata = mem[rd_ptr][AXIS_DATA_WIDTH-1:0];
            wfg_axis.tlast = mem[rd_ptr][AXIS_DATA_WIDTH];
        end
    end

endmodule
